fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V pipeline. It holds the PC, issues in-order word requests to instruction memory, and buffers returned words in a small prefetch FIFO. It presents each instruction, with its PC and the opcode/funct3/funct7 fields pre-split, to the decode stage over a valid/ready handshake. A redirect from branch/jump resolution (jal, jalr, taken B-type) flushes everything in flight and restarts fetch at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, default 2: prefetch FIFO entries; power of 2, ≥2; also the cap on outstanding requests plus buffered entries.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  32  word-aligned fetch address (bits [1:0] = 0).
- `imem_rsp_valid`  in  1  response valid; responses are in order, at most one per cycle, at least 1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle pulse: flush and refetch.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (treated as 0).
- `id_valid`  out  1  instruction available to decode.
- `id_ready`  in  1  decode accepts.
- `id_instr`  out  32  instruction word.
- `id_pc`  out  32  PC of `id_instr`.
- `id_opcode`  out  7  `id_instr[6:0]`.
- `id_funct3`  out  3  `id_instr[14:12]`.
- `id_funct7`  out  7  `id_instr[31:25]`.

## Operation
- State: `pc` (next address to request), FIFO of {pc, instr}, `outstanding` count (accepted requests not yet answered), `discard` count (stale responses still to drop).
- Credit: `outstanding + occupancy − pop_this_cycle < FIFO_DEPTH`.
- `imem_req_valid = credit && !redirect_valid`. `imem_req_addr = pc`. On acceptance: `pc ← pc + 4` (wraps modulo 2^32) and `outstanding` increments.
- Response with `discard == 0`: push {request PC, data} into the FIFO. A per-request PC queue or equivalent tracks the request PC. Response with `discard > 0`: drop it and decrement `discard`. Every response decrements `outstanding`.
- Handshake: pop when `id_valid && id_ready`. Because of the credit rule, a push to a full FIFO cannot occur.
- Redirect, which takes priority over everything else in its cycle:
  - FIFO is cleared.
  - `pc ← {redirect_pc[31:2], 2'b00}`.
  - `discard ← outstanding − (imem_rsp_valid ? 1 : 0)`, counted before that cycle's own response. The same-cycle response is dropped.
  - No request is issued in the redirect cycle.
  - An instruction handshaken in the redirect cycle counts as delivered.
- Redirect while `discard > 0`: `discard` is recomputed by the same rule, which is cumulative and correct because `outstanding` includes the older stale requests.
- `id_*` fields come combinationally from the FIFO head. When `id_valid` is 0 they are don't-care.

## Timing
- Values during reset: `pc = RESET_PC`, FIFO empty, `outstanding = 0`, `discard = 0`, `id_valid = 0`, `imem_req_valid = 0`.
- Reset can assert at any time. It aborts all state immediately, and any responses that belong to pre-reset requests must not be returned by memory.
- `imem_req_valid` rises in the first cycle after `rst_n` deasserts.
- Latency: request accepted in cycle t, response in cycle t+1, `id_valid` in cycle t+2. There is no response-to-decode bypass.
- Throughput: with 1-cycle memory latency, `FIFO_DEPTH = 2` and `id_ready` held high, the block sustains 1 instruction/cycle.
- After redirect in cycle r: first new request in r+1 and, with 1-cycle memory, first new `id_valid` in r+3.
- Holding `id_ready` low stalls fetch once `outstanding + occupancy = FIFO_DEPTH`. `id_*` stays stable while `id_valid && !id_ready`.

## Configuration
- `FETCH_STATS_EN` defined: adds the following outputs, both cleared by reset and wrapping on overflow:
  - `stat_fetched`, out, 32: +1 per id handshake.
  - `stat_redirects`, out, 16: +1 per `redirect_valid` cycle.
- Not defined: these ports and their counters are absent, and the remaining behaviour is identical.

## Test plan
- Reset release, memory with 1-cycle latency and `id_ready = 1` → requests to 0x0, 0x4, 0x8… on consecutive cycles. `id_valid` from cycle 2, one instruction per cycle, `id_pc` 0x0, 0x4, 0x8; 0x00500093 presents `id_opcode = 0x13`, `id_funct3 = 0`.
- Hold `id_ready = 0` for 10 cycles → at most 2 requests accepted, `id_pc = 0x0` stable. Release → 0x0, 0x4 delivered, then fetch resumes at 0x8.
- Memory with 3-cycle latency, redirect to 0x103 while 2 requests are outstanding → both old responses dropped, next request addr 0x100, first `id_pc = 0x100`.
- Redirect in the same cycle as a response and a decode handshake → handshaken instruction delivered once, response dropped, FIFO empty next cycle.
- Redirect to 0xFFFF_FFFC → requests 0xFFFF_FFFC then 0x0000_0000 (wrap).
- `rst_n` low mid-stream with FIFO full → `id_valid` and `imem_req_valid` drop immediately. After release, fetch restarts at `RESET_PC`; with `FETCH_STATS_EN`, both counters read 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//
// Holds the PC and issues in-order word requests to instruction memory. Returned
// words are buffered in a small prefetch FIFO. Each instruction is presented to
// decode with its PC and pre-split opcode/funct3/funct7 over a valid/ready
// handshake. A redirect flushes the FIFO, marks every in-flight response as stale
// and restarts fetch at the new PC.
//
// Parameters:
//   RESET_PC    first PC fetched after reset
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2); also caps outstanding + buffered
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   imem_req_valid/ready/addr         fetch request channel (word aligned)
//   imem_rsp_valid/data               in-order response channel
//   redirect_valid/redirect_pc        one-cycle flush-and-refetch pulse
//   id_valid/ready                    decode handshake
//   id_instr/pc/opcode/funct3/funct7  instruction at FIFO head
//
// Optional build macro FETCH_STATS_EN adds stat_fetched (decode handshakes) and
// stat_redirects (redirect cycles); both wrap and clear on reset.

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [15:0] stat_redirects
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Counters must be able to hold FIFO_DEPTH itself.
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] CntDepth = CntW'(FIFO_DEPTH);

  logic [31:0]     pc_q, pc_d;
  // PC of the next non-stale response; requests after a redirect are sequential,
  // so one running PC replaces a per-request PC queue.
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0] fifo_instr [FIFO_DEPTH];

  logic            pop;
  logic            push;
  logic            drop;
  logic            req_fire;
  logic            credit;
  logic [CntW-1:0] inflight;

  always_comb begin
    id_valid = (count_q != '0);
    pop      = id_valid && id_ready;
    // Entries freed by this cycle's pop can be re-requested in the same cycle.
    inflight = outstanding_q + count_q - CntW'(pop);
    credit   = (inflight < CntDepth);
    // Gated by rst_n so no request is visible while reset is held.
    imem_req_valid = rst_n && credit && !redirect_valid;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response in the redirect cycle is stale and is dropped.
    push = imem_rsp_valid && !redirect_valid && (discard_q == '0);
    drop = imem_rsp_valid && !redirect_valid && (discard_q != '0);
  end

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);

    if (redirect_valid) begin
      pc_d      = redirect_pc & 32'hFFFF_FFFC;
      rsp_pc_d  = redirect_pc & 32'hFFFF_FFFC;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      // Everything still in flight is stale, except a response arriving now,
      // which is dropped directly.
      discard_d = outstanding_q - CntW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (drop) begin
        discard_d = discard_q - CntOne;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= rsp_pc_q;
      fifo_instr[wr_ptr_q] <= imem_rsp_data;
    end
  end

  always_comb begin
    id_instr  = fifo_instr[rd_ptr_q];
    id_pc     = fifo_pc[rd_ptr_q];
    id_opcode = id_instr[6:0];
    id_funct3 = id_instr[14:12];
    id_funct7 = id_instr[31:25];
  end

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [15:0] stat_redirects_q, stat_redirects_d;

  always_comb begin
    // A handshake in a redirect cycle still counts as delivered.
    stat_fetched_d   = stat_fetched_q + 32'(pop);
    stat_redirects_d = stat_redirects_q + 16'(redirect_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched_q   <= '0;
      stat_redirects_q <= '0;
    end else begin
      stat_fetched_q   <= stat_fetched_d;
      stat_redirects_q <= stat_redirects_d;
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_redirects = stat_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a latency-configurable memory model.

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_redirects;
`endif

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_opcode     (id_opcode),
    .id_funct3     (id_funct3),
    .id_funct7     (id_funct7)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched  (stat_fetched),
    .stat_redirects(stat_redirects)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model state and observation logs.
  int          lat = 1;
  int          mcyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [31:0] del_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_addr.delete();
      mq_due.delete();
      mcyc = 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(mcyc + lat);
        req_log.push_back(imem_req_addr);
      end
      if (id_valid && id_ready) del_log.push_back(id_pc);
      mcyc = mcyc + 1;
      if (mq_addr.size() > 0 && mq_due[0] <= mcyc) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b1;
    lat            = 1;

    // T1: reset values, then streaming at 1 instr/cycle.
    repeat (3) next();
    settle();
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_id_valid", id_valid, 1'b0);
`ifdef FETCH_STATS_EN
    chk("rst_stat_fetched", stat_fetched, 32'h0);
    chk("rst_stat_redirects", stat_redirects, 32'h0);
`endif
    rst_n = 1'b1;
    settle();                                  // cycle 0
    chk("c0_req_valid", imem_req_valid, 1'b1);
    chk("c0_req_addr", imem_req_addr, 32'h0);
    chk("c0_id_valid", id_valid, 1'b0);
    next();                                    // cycle 1
    chk("c1_req_addr", imem_req_addr, 32'h4);
    chk("c1_id_valid_no_bypass", id_valid, 1'b0);
    next();                                    // cycle 2
    chk("c2_id_valid", id_valid, 1'b1);
    chk("c2_id_pc", id_pc, 32'h0);
    chk("c2_id_instr", id_instr, 32'h0050_0093);
    chk("c2_id_opcode", id_opcode, 7'h13);
    chk("c2_id_funct3", id_funct3, 3'h0);
    chk("c2_id_funct7", id_funct7, 7'h00);
    chk("c2_req_valid", imem_req_valid, 1'b1);
    chk("c2_req_addr", imem_req_addr, 32'h8);
    next();                                    // cycle 3
    chk("c3_id_pc", id_pc, 32'h4);
    next();                                    // cycle 4
    chk("c4_id_valid", id_valid, 1'b1);
    chk("c4_id_pc", id_pc, 32'h8);

    // T6: fill the FIFO, then reset mid-stream.
    id_ready = 1'b0;
    repeat (3) next();
    settle();
    chk("full_id_valid", id_valid, 1'b1);
    chk("full_id_pc_stable", id_pc, 32'h8);
    chk("full_req_stalled", imem_req_valid, 1'b0);
    rst_n = 1'b0;
    settle();
    chk("midrst_id_valid", id_valid, 1'b0);
    chk("midrst_req_valid", imem_req_valid, 1'b0);
`ifdef FETCH_STATS_EN
    chk("midrst_stat_fetched", stat_fetched, 32'h0);
    chk("midrst_stat_redirects", stat_redirects, 32'h0);
`endif

    // T2: decode stalled for 10 cycles from reset release.
    repeat (2) next();
    req_log.delete();
    del_log.delete();
    rst_n = 1'b1;
    settle();
    chk("stall_first_addr", imem_req_addr, 32'h0);
    for (int i = 0; i < 10; i++) begin
      next();
      if (id_valid) chk("stall_id_pc", id_pc, 32'h0);
    end
    chk("stall_req_count", 32'(req_log.size()), 32'd2);
    chk("stall_id_valid", id_valid, 1'b1);
    chk("stall_del_count", 32'(del_log.size()), 32'd0);
    id_ready = 1'b1;
    repeat (4) next();
    chk("release_del0", del_log[0], 32'h0);
    chk("release_del1", del_log[1], 32'h4);
    chk("release_req2", req_log[2], 32'h8);

    // T3: 3-cycle memory, redirect with two requests outstanding.
    rst_n = 1'b0;
    lat   = 3;
    repeat (2) next();
    rst_n = 1'b1;
    settle();                                  // cycle 0
    next();                                    // cycle 1
    next();                                    // cycle 2: two outstanding
    chk("r3_stalled", imem_req_valid, 1'b0);
    req_log.delete();
    del_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    settle();
    chk("r3_no_req_in_redirect", imem_req_valid, 1'b0);
    next();
    redirect_valid = 1'b0;
    settle();
    chk("r3_next_addr", imem_req_addr, 32'h100);
    repeat (12) next();
    chk("r3_req0", req_log[0], 32'h100);
    chk("r3_del0", del_log[0], 32'h100);
    chk("r3_del1", del_log[1], 32'h104);
`ifdef FETCH_STATS_EN
    chk("r3_stat_redirects", stat_redirects, 32'h1);
`endif

    // T4: redirect coinciding with a response and a decode handshake.
    rst_n = 1'b0;
    lat   = 1;
    repeat (2) next();
    del_log.delete();
    rst_n = 1'b1;
    settle();                                  // cycle 0
    repeat (3) next();                         // cycle 3
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    settle();
    chk("r4_id_valid", id_valid, 1'b1);
    chk("r4_id_pc", id_pc, 32'h4);
    chk("r4_rsp_same_cycle", imem_rsp_valid, 1'b1);
    next();                                    // cycle 4
    redirect_valid = 1'b0;
    settle();
    chk("r4_fifo_empty", id_valid, 1'b0);
    chk("r4_req_valid", imem_req_valid, 1'b1);
    chk("r4_req_addr", imem_req_addr, 32'h200);
    next();                                    // cycle 5
    chk("r4_c5_id_valid", id_valid, 1'b0);
    next();                                    // cycle 6
    chk("r4_c6_id_valid", id_valid, 1'b1);
    chk("r4_c6_id_pc", id_pc, 32'h200);
    chk("r4_del0", del_log[0], 32'h0);
    chk("r4_del1_once", del_log[1], 32'h4);
    chk("r4_del_count", 32'(del_log.size()), 32'd2);

    // T5: redirect to the top of the address space, fetch wraps to 0.
    req_log.delete();
    del_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    next();
    redirect_valid = 1'b0;
    settle();
    chk("r5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    repeat (6) next();
    chk("r5_req0", req_log[0], 32'hFFFF_FFFC);
    chk("r5_req1_wrap", req_log[1], 32'h0);
    chk("r5_req2", req_log[2], 32'h4);
    chk("r5_del0", del_log[0], 32'h200);
    chk("r5_del1", del_log[1], 32'hFFFF_FFFC);
    chk("r5_del2", del_log[2], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
